seg7_scan_ctrl: RTL and testbench

//  Parametrised time-multiplexed 7-segment display controller. Holds one
//  hex nibble and one decimal point per digit, written through a simple write

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_lz_mask.sv | 22 ++
 rtl/seg7_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment decode for the 7-segment scan controller.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] val;
  } digit_t;

  // Active-high "all segments dark"; polarity is applied at the output stage.
  localparam seg_t SEG_OFF = 7'h00;

  function automatic seg_t hex2seg(input logic [3:0] val);
    seg_t s;
    case (val)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero blank mask: digit i>0 is blanked when it and every digit above it are zero.
module seg7_lz_mask #(
  parameter int N_DIGITS = 8
) (
  input  logic                    blank_lz_i,
  input  logic [4*N_DIGITS-1:4]   vals_i,
  output logic [N_DIGITS-1:0]     blank_o
);

  logic zero_above_s;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank_o      = '0;
    zero_above_s = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      zero_above_s = zero_above_s & (vals_i[4*i +: 4] == 4'h0);
      blank_o[i]   = blank_lz_i & zero_above_s;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment controller: digit register file, scan divider,
// registered one-hot anode / segment / dp outputs with selectable pin polarity.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        blank_lz,
  input  logic                        wr_en,
  input  logic [$clog2(N_DIGITS)-1:0] wr_pos,
  input  logic [3:0]                  wr_dig,
  input  logic                        wr_dp,
  output logic [6:0]                  seg,
  output logic                        dp,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] scan_pos
);

  localparam int            PW       = $clog2(N_DIGITS);
  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(N_DIGITS - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  digit_t                digits_q [N_DIGITS];
  logic [DW-1:0]         div_q, div_d;
  logic [PW-1:0]         scan_pos_q, scan_pos_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  wr_ok_s;
  logic [4*N_DIGITS-1:4] vals_s;
  logic [N_DIGITS-1:0]   blank_s;
  digit_t                lit_s;
  logic [N_DIGITS-1:0]   an_raw_s;
  seg_t                  seg_raw_s;
  logic                  dp_raw_s;

  // A power-of-two digit count makes every encodable position valid.
  generate
    if ((1 << PW) == N_DIGITS) begin : g_wr_full
      assign wr_ok_s = 1'b1;
    end else begin : g_wr_range
      assign wr_ok_s = (wr_pos <= POS_LAST);
    end
  endgenerate

  // Digit register file; writes land regardless of enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        digits_q[i] <= '0;
      end
    end else if (wr_en && wr_ok_s) begin
      digits_q[wr_pos] <= '{dp: wr_dp, val: wr_dig};
    end
  end

  // Upper digit values feed the leading-zero mask.
  always_comb begin
    vals_s = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      vals_s[4*i +: 4] = digits_q[i].val;
    end
  end

  seg7_lz_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_lz_mask (
    .blank_lz_i (blank_lz),
    .vals_i     (vals_s),
    .blank_o    (blank_s)
  );

  // Divider and scan position advance only while enabled.
  always_comb begin
    div_d      = div_q;
    scan_pos_d = scan_pos_q;
    if (enable) begin
      if (div_q == DIV_LAST) begin
        div_d      = '0;
        scan_pos_d = (scan_pos_q == POS_LAST) ? '0 : scan_pos_q + PW'(1);
      end else begin
        div_d      = div_q + DW'(1);
      end
    end else begin
      div_d      = div_q;
      scan_pos_d = scan_pos_q;
    end
  end

  // Next output values built active-high, then polarity-adjusted.
  always_comb begin
    lit_s     = digits_q[scan_pos_q];
    an_raw_s  = '0;
    seg_raw_s = SEG_OFF;
    dp_raw_s  = 1'b0;
    if (enable) begin
      an_raw_s[scan_pos_q] = 1'b1;
      if (blank_s[scan_pos_q]) begin
        seg_raw_s = SEG_OFF;
      end else begin
        seg_raw_s = hex2seg(lit_s.val);
      end
      dp_raw_s = lit_s.dp;
    end else begin
      an_raw_s  = '0;
      seg_raw_s = SEG_OFF;
      dp_raw_s  = 1'b0;
    end
    an_d  = an_raw_s ^ {N_DIGITS{INV}};
    seg_d = seg_raw_s ^ {7{INV}};
    dp_d  = dp_raw_s ^ INV;
  end

  // Scan state and output registers; reset forces every pin to its dark level.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q      <= '0;
      scan_pos_q <= '0;
      an_q       <= {N_DIGITS{INV}};
      seg_q      <= {7{INV}};
      dp_q       <= INV;
    end else begin
      div_q      <= div_d;
      scan_pos_q <= scan_pos_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign scan_pos = scan_pos_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: an 8-digit active-low instance plus a 6-digit active-high
// instance that can be addressed beyond its last digit.
module tb_seg7_scan_ctrl;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       blank_lz;
  logic       wr_en;
  logic [2:0] wr_pos;
  logic [3:0] wr_dig;
  logic       wr_dp;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic [2:0] scan_pos;

  logic       w6_en;
  logic [2:0] w6_pos;
  logic [3:0] w6_dig;
  logic       w6_dp;
  logic [6:0] seg6;
  logic       dp6;
  logic [5:0] an6;
  logic [2:0] scan_pos6;

  int total;
  int bad;

  seg7_scan_ctrl #(.N_DIGITS(8), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_dig(wr_dig), .wr_dp(wr_dp),
    .seg(seg), .dp(dp), .an(an), .scan_pos(scan_pos)
  );

  seg7_scan_ctrl #(.N_DIGITS(6), .SCAN_DIV(2), .ACTIVE_LOW(0)) u_dut6 (
    .clock(clock), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .wr_en(w6_en), .wr_pos(w6_pos), .wr_dig(w6_dig), .wr_dp(w6_dp),
    .seg(seg6), .dp(dp6), .an(an6), .scan_pos(scan_pos6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr8(input logic [2:0] p, input logic [3:0] v, input logic d);
    wr_en = 1'b1; wr_pos = p; wr_dig = v; wr_dp = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] p, input logic [3:0] v, input logic d);
    w6_en = 1'b1; w6_pos = p; w6_dig = v; w6_dp = d;
    tick();
    w6_en = 1'b0;
  endtask

  task automatic wait_an(input logic [7:0] tgt, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (an !== tgt && n < 64);
    total++;
    if (an !== tgt) begin
      bad++;
      $display("FAIL %s wait_an: an=%h want %h", name, an, tgt);
    end
  endtask

  task automatic wait_an6(input logic [5:0] tgt, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (an6 !== tgt && n < 64);
    total++;
    if (an6 !== tgt) begin
      bad++;
      $display("FAIL %s wait_an6: an6=%h want %h", name, an6, tgt);
    end
  endtask

  task automatic chk_lit(input string name, input logic [6:0] exp_seg, input logic exp_dp);
    total++;
    if (seg !== exp_seg || dp !== exp_dp) begin
      bad++;
      $display("FAIL %s: seg=%h dp=%b want seg=%h dp=%b", name, seg, dp, exp_seg, exp_dp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; blank_lz = 1'b0;
    wr_en = 1'b0; wr_pos = 3'd0; wr_dig = 4'h0; wr_dp = 1'b0;
    w6_en = 1'b0; w6_pos = 3'd0; w6_dig = 4'h0; w6_dp = 1'b0;
    tick(); tick();
    total++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || scan_pos !== 3'd0) begin
      bad++;
      $display("FAIL reset8: an=%h seg=%h dp=%b pos=%0d want FF 7F 1 0", an, seg, dp, scan_pos);
    end
    total++;
    if (an6 !== 6'h00 || seg6 !== 7'h00 || dp6 !== 1'b0 || scan_pos6 !== 3'd0) begin
      bad++;
      $display("FAIL reset6: an=%h seg=%h dp=%b pos=%0d want 00 00 0 0", an6, seg6, dp6, scan_pos6);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [7:0] exp_an;
    for (int d = 0; d < 9; d++) begin
      exp_an = ~(8'h01 << (d % 8));
      for (int c = 0; c < 4; c++) begin
        tick();
        total++;
        if (an !== exp_an || seg !== 7'h40 || dp !== 1'b1) begin
          bad++;
          $display("FAIL scan d=%0d c=%0d: an=%h seg=%h dp=%b want %h 40 1", d, c, an, seg, dp, exp_an);
        end
      end
    end
  endtask

  task automatic test_write();
    wr8(3'd3, 4'hA, 1'b1);
    wait_an(8'hF7, "wrA");
    chk_lit("wrA_pos3", 7'h08, 1'b0);
    wait_an(8'hEF, "wrA4");
    chk_lit("wrA_pos4", 7'h40, 1'b1);
    wait_an(8'hFB, "wrA2");
    chk_lit("wrA_pos2", 7'h40, 1'b1);
  endtask

  task automatic test_lz();
    logic [6:0] exp_seg [8];
    blank_lz = 1'b1;
    wr8(3'd0, 4'h3, 1'b0);
    wr8(3'd1, 4'h2, 1'b0);
    wr8(3'd2, 4'h1, 1'b0);
    wr8(3'd3, 4'h0, 1'b0);
    exp_seg = '{7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int p = 0; p < 8; p++) begin
      wait_an(~(8'h01 << p), "lz123");
      chk_lit($sformatf("lz123_pos%0d", p), exp_seg[p], 1'b1);
    end
    wr8(3'd0, 4'h0, 1'b0);
    wr8(3'd1, 4'h0, 1'b0);
    wr8(3'd2, 4'h0, 1'b0);
    wr8(3'd5, 4'h0, 1'b1);
    for (int p = 0; p < 8; p++) begin
      wait_an(~(8'h01 << p), "lz0");
      chk_lit($sformatf("lz0_pos%0d", p), (p == 0) ? 7'h40 : 7'h7F, (p == 5) ? 1'b0 : 1'b1);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_enable();
    wait_an(8'hFB, "en_sync");
    tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        wr_en = 1'b1; wr_pos = 3'd2; wr_dig = 4'h5; wr_dp = 1'b0;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      total++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || scan_pos !== 3'd2) begin
        bad++;
        $display("FAIL dis%0d: an=%h seg=%h dp=%b pos=%0d want FF 7F 1 2", i, an, seg, dp, scan_pos);
      end
    end
    enable = 1'b1;
    tick();
    total++;
    if (an !== 8'hFB || seg !== 7'h12 || scan_pos !== 3'd2) begin
      bad++;
      $display("FAIL reen1: an=%h seg=%h pos=%0d want FB 12 2", an, seg, scan_pos);
    end
    tick();
    total++;
    if (an !== 8'hFB || scan_pos !== 3'd3) begin
      bad++;
      $display("FAIL reen2: an=%h pos=%0d want FB 3", an, scan_pos);
    end
    tick();
    total++;
    if (an !== 8'hF7) begin
      bad++;
      $display("FAIL reen3: an=%h want F7", an);
    end
  endtask

  task automatic test_lit_write();
    wait_an(8'hBF, "lit_sync");
    wr8(3'd6, 4'h8, 1'b0);
    chk_lit("lit_edge_k", 7'h40, 1'b1);
    tick();
    total++;
    if (an !== 8'hBF || seg !== 7'h00) begin
      bad++;
      $display("FAIL lit_edge_k1: an=%h seg=%h want BF 00", an, seg);
    end
  endtask

  task automatic test_out_of_range();
    wr6(3'd6, 4'h8, 1'b1);
    wr6(3'd7, 4'hF, 1'b1);
    wr6(3'd5, 4'h1, 1'b1);
    for (int p = 0; p < 6; p++) begin
      wait_an6(6'h01 << p, "oor");
      total++;
      if (seg6 !== ((p == 5) ? 7'h06 : 7'h3F) || dp6 !== (p == 5)) begin
        bad++;
        $display("FAIL oor_pos%0d: seg=%h dp=%b want %h %b", p, seg6, dp6,
                 (p == 5) ? 7'h06 : 7'h3F, (p == 5));
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_an(8'hDF, "rst_sync");
    tick();
    total++;
    if (scan_pos !== 3'd5 || dp !== 1'b0) begin
      bad++;
      $display("FAIL pre_rst: pos=%0d dp=%b want 5 0", scan_pos, dp);
    end
    reset = 1'b1;
    wr_en = 1'b1; wr_pos = 3'd1; wr_dig = 4'h9; wr_dp = 1'b1;
    tick();
    total++;
    if (scan_pos !== 3'd0 || an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: pos=%0d an=%h seg=%h dp=%b want 0 FF 7F 1", scan_pos, an, seg, dp);
    end
    reset = 1'b0;
    wr_en = 1'b0;
    tick();
    total++;
    if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
      bad++;
      $display("FAIL post_rst: an=%h seg=%h dp=%b want FE 40 1", an, seg, dp);
    end
    wait_an(8'hFD, "clr1");
    chk_lit("clr_pos1", 7'h40, 1'b1);
    wait_an(8'hFB, "clr2");
    chk_lit("clr_pos2", 7'h40, 1'b1);
    wait_an(8'hDF, "clr5");
    chk_lit("clr_pos5", 7'h40, 1'b1);
    wait_an(8'hBF, "clr6");
    chk_lit("clr_pos6", 7'h40, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_scan();
    test_write();
    test_lz();
    test_enable();
    test_lit_write();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
